// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MUL_HI = 2'd1,
    DIV_Q  = 2'd2,
    DIV_R  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient returned on divide by zero; sliced to the operand width by users.
  localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/mux_4.sv
// Generic 4:1 word multiplexer.
module mux_4 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider feeding the accumulator.
// Optional MULDIV_EARLY_EXIT_EN: multiplies finish once the remaining multiplier is zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t                 r_state, w_next;
  op_t                    r_op;
  logic [2*WIDTH-1:0]     r_prod, r_mcand;
  logic [WIDTH-1:0]       r_mplier, r_quo, r_rem, r_div;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_result;
  logic                   r_dz;

  logic                   w_accept, w_opb_zero, w_dz_in, w_fast, w_fast_go;
  logic                   w_last, w_load, w_ge;
  logic [2*WIDTH-1:0]     w_prod_nxt;
  logic [WIDTH-1:0]       w_mplier_nxt, w_rem_nxt, w_quo_nxt, w_mux;
  logic [WIDTH:0]         w_rem_sh, w_diff;
  op_t                    w_sel;

  assign w_accept   = start && (r_state != RUN);
  assign w_opb_zero = (opb == '0);
  assign w_dz_in    = op[1] && w_opb_zero;
`ifdef MULDIV_EARLY_EXIT_EN
  assign w_fast     = w_dz_in || (!op[1] && w_opb_zero);
`else
  assign w_fast     = w_dz_in;
`endif
  assign w_fast_go  = w_accept && w_fast;

  assign w_prod_nxt   = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_nxt = r_mplier >> 1;

  // Sign of (shifted remainder - divisor) decides the quotient bit.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_div};
  assign w_ge      = !w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

`ifdef MULDIV_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) ||
                  ((r_op == MUL_LO || r_op == MUL_HI) && w_mplier_nxt == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

  // Result is latched on entry to DONE, so the mux sees next-iteration values
  // in RUN and the raw request on the zero-operand shortcut.
  assign w_load = ((r_state == RUN) && w_last) || w_fast_go;
  assign w_sel  = (r_state == RUN) ? r_op : op_t'(op);

  mux_4 #(.WIDTH(WIDTH)) u_res_mux (
    .sel (w_sel),
    .d0  (w_fast_go ? '0 : w_prod_nxt[WIDTH-1:0]),
    .d1  (w_fast_go ? '0 : w_prod_nxt[2*WIDTH-1:WIDTH]),
    .d2  (w_fast_go ? DZ_QUOTIENT[WIDTH-1:0] : w_quo_nxt),
    .d3  (w_fast_go ? opa : w_rem_nxt),
    .y   (w_mux)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) w_next = w_fast ? DONE : RUN;
        else       w_next = IDLE;
      end
      RUN:     if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_op     <= MUL_LO;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_dz     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= op_t'(op);
        r_prod   <= '0;
        r_rem    <= '0;
        r_cnt    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, opa};
        r_mplier <= opb;
        r_quo    <= opa;
        r_div    <= opb;
      end else if (r_state == RUN) begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
        r_mplier <= w_mplier_nxt;
        r_rem    <= w_rem_nxt;
        r_quo    <= w_quo_nxt;
        r_cnt    <= r_cnt + CW'(1);
      end
      if (w_load) begin
        r_result <= w_mux;
        r_dz     <= w_fast_go && w_dz_in;
      end
    end
  end

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign result = r_result;
  assign dz     = r_dz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: results, dz flag, latency, reset, back-to-back.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 8;

  logic         CLK, RST, start;
  logic [1:0]   op;
  logic [W-1:0] opa, opb;
  logic         busy, done, dz;
  logic [W-1:0] result;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .dz(dz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [1:0] o,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [2*W-1:0] p;
    p     = a * b;
    e.tag = tag;
    e.dz  = o[1] && (b == 0);
    case (o)
      2'd0:    e.res = p[W-1:0];
      2'd1:    e.res = p[2*W-1:W];
      2'd2:    e.res = (b == 0) ? {W{1'b1}} : a / b;
      default: e.res = (b == 0) ? a : a % b;
    endcase
    if (e.dz) e.lat = 0;
    else if (!o[1]) begin
`ifdef MULDIV_EARLY_EXIT_EN
      e.lat = 0;
      for (int i = 0; i < W; i++) if (b[i]) e.lat = i + 1;
`else
      e.lat = W;
`endif
    end else e.lat = W;
    return e;
  endfunction

  // Drive a request on the falling edge; returns #1 after the sampling edge.
  task automatic drive(input string tag, input logic [1:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    start = 1'b1; op = o; opa = a; opb = b;
    sb.push_back(model(tag, o, a, b));
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int pre);
    int   cnt;
    exp_t e;
    cnt = pre;
    while (done !== 1'b1 && cnt < 40) begin
      @(posedge CLK);
      #1 cnt++;
    end
    e = sb.pop_front();
    chk({e.tag, "_done"}, done, 1);
    chk({e.tag, "_lat"}, cnt, e.lat);
    chk({e.tag, "_res"}, result, e.res);
    chk({e.tag, "_dz"}, dz, e.dz);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; op = 2'd0; opa = '0; opb = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_dz", dz, 0);
    @(negedge CLK) RST = 1'b0;

    drive("mul_lo_13x11", 2'd0, 8'd13, 8'd11);
    chk("t1_busy", busy, 1);
    wait_done(0);
    @(posedge CLK);
    #1;
    chk("t1_done_low", done, 0);
    chk("t1_res_held", result, 8'h8F);

    drive("mul_hi_200x200", 2'd1, 8'd200, 8'd200);
    wait_done(0);
    drive("mul_lo_200x200", 2'd0, 8'd200, 8'd200);
    chk("b2b_busy", busy, 1);
    wait_done(0);

    drive("divq_200_7", 2'd2, 8'd200, 8'd7);
    opa = '0; opb = '0;
    wait_done(0);
    drive("divr_200_7", 2'd3, 8'd200, 8'd7);
    opa = '0; opb = '0;
    wait_done(0);

    drive("divq_dz", 2'd2, 8'h55, 8'h00);
    wait_done(0);
    drive("divr_dz", 2'd3, 8'h55, 8'h00);
    wait_done(0);
    drive("mul_2x3", 2'd0, 8'd2, 8'd3);
    wait_done(0);

    drive("mul_ign_start", 2'd0, 8'd13, 8'd11);
    @(negedge CLK);
    start = 1'b1; op = 2'd2; opa = 8'd1; opb = 8'd0;
    @(posedge CLK);
    #1 start = 1'b0;
    wait_done(1);

    drive("mul_rst", 2'd1, 8'd200, 8'd200);
    @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_res", result, 0);
    chk("midrst_dz", dz, 0);
    void'(sb.pop_back());
    @(negedge CLK) RST = 1'b0;

    drive("mul_5x3", 2'd0, 8'd5, 8'd3);
    wait_done(0);
    drive("mul_9x0", 2'd0, 8'd9, 8'd0);
    wait_done(0);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      drive("rand", ro, ra, rb);
      wait_done(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
